// File: rtl/me_mb_if.sv
// Handshake and payload bundle between the macroblock scheduler, the ME controller and the result consumer.
// ME_SKIP_EN adds the skip threshold input and skip flag output.
interface me_mb_if;
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned SAD_W  = 16;
  localparam int unsigned MV_W   = 10;
  localparam int unsigned FSAD_W = 24;

  logic              start;
  logic              abort;
  logic              busy;
  logic              done;
  logic              me_req;
  logic              me_ack;
  logic [SAD_W-1:0]  me_min_sad;
  logic [MV_W-1:0]   me_min_mvec;
  logic [IDX_W-1:0]  mb_x;
  logic [IDX_W-1:0]  mb_y;
  logic              res_valid;
  logic              res_ready;
  logic [SAD_W-1:0]  res_sad;
  logic [MV_W-1:0]   res_mvec;
  logic [IDX_W-1:0]  res_mb_x;
  logic [IDX_W-1:0]  res_mb_y;
  logic [FSAD_W-1:0] frame_sad;
`ifdef ME_SKIP_EN
  logic [SAD_W-1:0]  skip_thresh;
  logic              res_skip;
`endif

  // Scheduler side
  modport master (
    input  start, abort, me_ack, me_min_sad, me_min_mvec, res_ready,
`ifdef ME_SKIP_EN
    input  skip_thresh,
    output res_skip,
`endif
    output busy, done, me_req, mb_x, mb_y, res_valid,
    output res_sad, res_mvec, res_mb_x, res_mb_y, frame_sad
  );

  // Controller / consumer / host side
  modport slave (
    output start, abort, me_ack, me_min_sad, me_min_mvec, res_ready,
`ifdef ME_SKIP_EN
    output skip_thresh,
    input  res_skip,
`endif
    input  busy, done, me_req, mb_x, mb_y, res_valid,
    input  res_sad, res_mvec, res_mb_x, res_mb_y, frame_sad
  );
endinterface

// File: rtl/me_mb_scheduler.sv
// Raster-order macroblock scheduler: requests one ME search per MB, forwards results, accumulates frame SAD.
// Optional feature macro ME_SKIP_EN: flags MBs whose best SAD is at or below skip_thresh.
module me_mb_scheduler #(
  parameter int unsigned MB_COLS = 4,
  parameter int unsigned MB_ROWS = 4
) (
  input logic      clk,
  input logic      rst_n,
  me_mb_if.master  bus
);
  localparam int unsigned IDX_W  = 6;
  localparam int unsigned SAD_W  = 16;
  localparam int unsigned MV_W   = 10;
  localparam int unsigned FSAD_W = 24;
  localparam logic [IDX_W-1:0]  LAST_X   = IDX_W'(MB_COLS - 1);
  localparam logic [IDX_W-1:0]  LAST_Y   = IDX_W'(MB_ROWS - 1);
  localparam logic [FSAD_W-1:0] FSAD_MAX = '1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT_ACK_LOW,
    S_OUTPUT
  } state_e;

  state_e state_q, state_d;

  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              me_req_q, me_req_d;
  logic              res_valid_q, res_valid_d;
  logic [IDX_W-1:0]  mb_x_q, mb_x_d;
  logic [IDX_W-1:0]  mb_y_q, mb_y_d;
  logic [FSAD_W-1:0] frame_sad_q, frame_sad_d;
  logic [SAD_W-1:0]  res_sad_q, res_sad_d;
  logic [MV_W-1:0]   res_mvec_q, res_mvec_d;
  logic [IDX_W-1:0]  res_mb_x_q, res_mb_x_d;
  logic [IDX_W-1:0]  res_mb_y_q, res_mb_y_d;
`ifdef ME_SKIP_EN
  logic              res_skip_q, res_skip_d;
  logic              skip_hit_c;
`endif

  logic              start_c;
  logic              capture_c;
  logic              accept_c;
  logic              last_mb_c;
  logic [FSAD_W:0]   sad_sum_c;

  // Abort outranks every other event in the busy states.
  assign start_c   = (state_q == S_IDLE)   && bus.start     && !bus.abort;
  assign capture_c = (state_q == S_REQ)    && bus.me_ack    && !bus.abort;
  assign accept_c  = (state_q == S_OUTPUT) && bus.res_ready && !bus.abort;
  assign last_mb_c = (mb_x_q == LAST_X) && (mb_y_q == LAST_Y);
  assign sad_sum_c = {1'b0, frame_sad_q} + (FSAD_W + 1)'(res_sad_q);
`ifdef ME_SKIP_EN
  assign skip_hit_c = (bus.me_min_sad <= bus.skip_thresh);
`endif

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:         if (start_c)      state_d = S_REQ;
      S_REQ:          if (capture_c)    state_d = S_WAIT_ACK_LOW;
      S_WAIT_ACK_LOW: if (!bus.me_ack)  state_d = S_OUTPUT;
      S_OUTPUT:       if (accept_c)     state_d = last_mb_c ? S_IDLE : S_REQ;
      default:                          state_d = S_IDLE;
    endcase
    if ((state_q != S_IDLE) && bus.abort) begin
      state_d = S_IDLE;
    end
  end

  // Output and datapath next values; every output is registered from these.
  always_comb begin
    busy_d      = (state_d != S_IDLE);
    me_req_d    = (state_d == S_REQ);
    res_valid_d = (state_d == S_OUTPUT);
    done_d      = accept_c && last_mb_c;
    mb_x_d      = mb_x_q;
    mb_y_d      = mb_y_q;
    frame_sad_d = frame_sad_q;
    res_sad_d   = res_sad_q;
    res_mvec_d  = res_mvec_q;
    res_mb_x_d  = res_mb_x_q;
    res_mb_y_d  = res_mb_y_q;
`ifdef ME_SKIP_EN
    res_skip_d  = res_skip_q;
`endif

    if (start_c) begin
      mb_x_d      = '0;
      mb_y_d      = '0;
      frame_sad_d = '0;
    end

    if (capture_c) begin
      res_sad_d  = bus.me_min_sad;
      res_mb_x_d = mb_x_q;
      res_mb_y_d = mb_y_q;
`ifdef ME_SKIP_EN
      res_skip_d = skip_hit_c;
      res_mvec_d = skip_hit_c ? '0 : bus.me_min_mvec;
`else
      res_mvec_d = bus.me_min_mvec;
`endif
    end

    // Accumulate with saturation, then step raster position unless this was the final MB.
    if (accept_c) begin
      frame_sad_d = sad_sum_c[FSAD_W] ? FSAD_MAX : sad_sum_c[FSAD_W-1:0];
      if (!last_mb_c) begin
        if (mb_x_q == LAST_X) begin
          mb_x_d = '0;
          mb_y_d = mb_y_q + IDX_W'(1);
        end else begin
          mb_x_d = mb_x_q + IDX_W'(1);
        end
      end
    end
  end

  // Output and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      me_req_q    <= 1'b0;
      res_valid_q <= 1'b0;
      mb_x_q      <= '0;
      mb_y_q      <= '0;
      frame_sad_q <= '0;
      res_sad_q   <= '1;
      res_mvec_q  <= '0;
      res_mb_x_q  <= '0;
      res_mb_y_q  <= '0;
`ifdef ME_SKIP_EN
      res_skip_q  <= 1'b0;
`endif
    end else begin
      busy_q      <= busy_d;
      done_q      <= done_d;
      me_req_q    <= me_req_d;
      res_valid_q <= res_valid_d;
      mb_x_q      <= mb_x_d;
      mb_y_q      <= mb_y_d;
      frame_sad_q <= frame_sad_d;
      res_sad_q   <= res_sad_d;
      res_mvec_q  <= res_mvec_d;
      res_mb_x_q  <= res_mb_x_d;
      res_mb_y_q  <= res_mb_y_d;
`ifdef ME_SKIP_EN
      res_skip_q  <= res_skip_d;
`endif
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.me_req    = me_req_q;
  assign bus.res_valid = res_valid_q;
  assign bus.mb_x      = mb_x_q;
  assign bus.mb_y      = mb_y_q;
  assign bus.frame_sad = frame_sad_q;
  assign bus.res_sad   = res_sad_q;
  assign bus.res_mvec  = res_mvec_q;
  assign bus.res_mb_x  = res_mb_x_q;
  assign bus.res_mb_y  = res_mb_y_q;
`ifdef ME_SKIP_EN
  assign bus.res_skip  = res_skip_q;
`endif

endmodule

// File: tb/tb_me_mb_scheduler.sv
// Bench for me_mb_scheduler: a 2x2 instance checked every cycle against a frame-level model,
// plus a 32x32 instance driven directly to reach frame_sad saturation.
module tb_me_mb_scheduler;
  localparam int COLS_A = 2;
  localparam int ROWS_A = 2;
  localparam int COLS_B = 32;
  localparam int ROWS_B = 32;
  localparam int SKIP_T = 64;

  typedef struct {
    logic [5:0]  x;
    logic [5:0]  y;
    logic [15:0] sad;
    logic [9:0]  mvec;
    logic        skip;
  } rec_t;

  logic clk;
  logic rst_n;

  me_mb_if ia ();
  me_mb_if ib ();

  me_mb_scheduler #(.MB_COLS(COLS_A), .MB_ROWS(ROWS_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ia));
  me_mb_scheduler #(.MB_COLS(COLS_B), .MB_ROWS(ROWS_B)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ib));

  int tests = 0;
  int fails = 0;

  // Controller model knobs and the values it last presented with an ack
  int          cur_dly   = 0;
  int          low_dly   = 0;
  bit          rand_mode = 0;
  int          sad_plan[$];
  logic [9:0]  mv_log[$];
  logic [15:0] exp_sad   = '0;
  logic [9:0]  exp_mvec  = '0;
  logic        exp_skip  = 1'b0;
  int          done_cnt  = 0;
  rec_t        res_log[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] sat_add(input logic [23:0] a, input logic [15:0] b);
    longint s;
    s = longint'(a) + longint'(b);
    return (s > 64'hFFFFFF) ? 24'hFFFFFF : 24'(s);
  endfunction

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start_a();
    ia.start = 1'b1;
    cyc(1);
    ia.start = 1'b0;
  endtask

  task automatic wait_idle_a(input int budget);
    int n;
    n = 0;
    while (ia.busy && n < budget) begin
      cyc(1);
      n++;
    end
    chk("idle_timeout", 32'(ia.busy), 32'(0));
  endtask

  task automatic chk_reset_vals(input string tag, input logic busy, input logic done, input logic req,
                                input logic vld, input logic [5:0] x, input logic [5:0] y,
                                input logic [23:0] fs, input logic [15:0] rs, input logic [9:0] rm,
                                input logic [5:0] rx, input logic [5:0] ry);
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_done"}, 32'(done), 32'(0));
    chk({tag, "_me_req"}, 32'(req), 32'(0));
    chk({tag, "_res_valid"}, 32'(vld), 32'(0));
    chk({tag, "_mb_x"}, 32'(x), 32'(0));
    chk({tag, "_mb_y"}, 32'(y), 32'(0));
    chk({tag, "_frame_sad"}, 32'(fs), 32'(0));
    chk({tag, "_res_sad"}, 32'(rs), 32'h0000FFFF);
    chk({tag, "_res_mvec"}, 32'(rm), 32'(0));
    chk({tag, "_res_mb_x"}, 32'(rx), 32'(0));
    chk({tag, "_res_mb_y"}, 32'(ry), 32'(0));
  endtask

  // ME controller model for instance A: acks cur_dly cycles after me_req, drops ack low_dly cycles after me_req falls
  initial begin : ctl_a
    int         cnt;
    logic [15:0] s;
    logic [9:0]  m;
    cnt = 0;
    ia.me_ack      = 1'b0;
    ia.me_min_sad  = '0;
    ia.me_min_mvec = '0;
    forever begin
      @(posedge clk);
      #1;
      if (!rst_n) begin
        ia.me_ack = 1'b0;
        cnt = 0;
      end else if (!ia.me_ack) begin
        if (ia.me_req) begin
          if (cnt >= cur_dly) begin
            if (sad_plan.size() > 0) s = 16'(sad_plan.pop_front());
            else if ($urandom_range(0, 3) == 0) s = 16'($urandom_range(0, 128));
            else s = 16'($urandom);
            m = 10'($urandom_range(1, 1023));
            ia.me_ack      = 1'b1;
            ia.me_min_sad  = s;
            ia.me_min_mvec = m;
            mv_log.push_back(m);
            exp_sad = s;
`ifdef ME_SKIP_EN
            exp_skip = (int'(s) <= SKIP_T);
            exp_mvec = exp_skip ? 10'd0 : m;
`else
            exp_skip = 1'b0;
            exp_mvec = m;
`endif
            cnt = 0;
            if (rand_mode) begin
              cur_dly = $urandom_range(0, 4);
              low_dly = $urandom_range(0, 2);
            end
          end else begin
            cnt++;
          end
        end else begin
          cnt = 0;
        end
      end else if (!ia.me_req) begin
        if (cnt >= low_dly) begin
          ia.me_ack      = 1'b0;
          ia.me_min_sad  = 16'($urandom);
          ia.me_min_mvec = 10'($urandom);
          cnt = 0;
        end else begin
          cnt++;
        end
      end
    end
  end

  // Frame-level model of instance A, compared on every falling edge
  initial begin : cmp_a
    bit         m_busy;
    bit         m_done;
    int         m_idx;
    logic [23:0] m_fsad;
    rec_t       r;
    m_busy = 0;
    m_done = 0;
    m_idx  = 0;
    m_fsad = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_busy = 0;
        m_done = 0;
        m_idx  = 0;
        m_fsad = '0;
        continue;
      end
      chk("busy", 32'(ia.busy), 32'(m_busy));
      chk("done", 32'(ia.done), 32'(m_done));
      chk("frame_sad", 32'(ia.frame_sad), 32'(m_fsad));
      chk("mb_x", 32'(ia.mb_x), 32'(m_idx % COLS_A));
      chk("mb_y", 32'(ia.mb_y), 32'(m_idx / COLS_A));
      if (ia.done) done_cnt++;
      if (!m_busy) begin
        chk("idle_me_req", 32'(ia.me_req), 32'(0));
        chk("idle_res_valid", 32'(ia.res_valid), 32'(0));
      end
      if (ia.res_valid) begin
        chk("res_sad", 32'(ia.res_sad), 32'(exp_sad));
        chk("res_mvec", 32'(ia.res_mvec), 32'(exp_mvec));
        chk("res_mb_x", 32'(ia.res_mb_x), 32'(m_idx % COLS_A));
        chk("res_mb_y", 32'(ia.res_mb_y), 32'(m_idx / COLS_A));
        chk("req_while_valid", 32'(ia.me_req), 32'(0));
`ifdef ME_SKIP_EN
        chk("res_skip", 32'(ia.res_skip), 32'(exp_skip));
`endif
      end
      m_done = 0;
      if (m_busy && ia.abort) begin
        m_busy = 0;
      end else if (!m_busy && ia.start && !ia.abort) begin
        m_busy = 1;
        m_idx  = 0;
        m_fsad = '0;
      end else if (m_busy && ia.res_valid && ia.res_ready) begin
        r.x = ia.res_mb_x;
        r.y = ia.res_mb_y;
        r.sad = ia.res_sad;
        r.mvec = ia.res_mvec;
`ifdef ME_SKIP_EN
        r.skip = ia.res_skip;
`else
        r.skip = 1'b0;
`endif
        res_log.push_back(r);
        m_fsad = sat_add(m_fsad, exp_sad);
        if (m_idx == COLS_A * ROWS_A - 1) begin
          m_busy = 0;
          m_done = 1;
        end else begin
          m_idx++;
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int          n;
    int          n_req;
    int          lost;
    logic [23:0] bsum;
    int          ex_x[4];
    int          ex_y[4];
    int          ex_s[4];
    ex_x = '{0, 1, 0, 1};
    ex_y = '{0, 0, 1, 1};
    ex_s = '{100, 200, 50, 300};

    rst_n = 1'b0;
    ia.start = 1'b0; ia.abort = 1'b0; ia.res_ready = 1'b1;
    ib.start = 1'b0; ib.abort = 1'b0; ib.res_ready = 1'b1;
    ib.me_ack = 1'b0; ib.me_min_sad = '0; ib.me_min_mvec = '0;
`ifdef ME_SKIP_EN
    ia.skip_thresh = 16'(SKIP_T);
    ib.skip_thresh = '0;
`endif
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_vals("rst_a", ia.busy, ia.done, ia.me_req, ia.res_valid, ia.mb_x, ia.mb_y,
                   ia.frame_sad, ia.res_sad, ia.res_mvec, ia.res_mb_x, ia.res_mb_y);
    chk_reset_vals("rst_b", ib.busy, ib.done, ib.me_req, ib.res_valid, ib.mb_x, ib.mb_y,
                   ib.frame_sad, ib.res_sad, ib.res_mvec, ib.res_mb_x, ib.res_mb_y);
    #2 rst_n = 1'b1;
    cyc(2);

    // Directed 2x2 frame, 10-cycle ack latency, SADs 100/200/50/300
    cur_dly = 10; low_dly = 0; rand_mode = 0;
    sad_plan = '{100, 200, 50, 300};
    res_log.delete(); done_cnt = 0;
    pulse_start_a();
    wait_idle_a(400);
    cyc(3);
    chk("frame_results", 32'(res_log.size()), 32'(4));
    if (res_log.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk("frame_x", 32'(res_log[i].x), 32'(ex_x[i]));
        chk("frame_y", 32'(res_log[i].y), 32'(ex_y[i]));
        chk("frame_sad_item", 32'(res_log[i].sad), 32'(ex_s[i]));
      end
    end
    chk("frame_total", 32'(ia.frame_sad), 32'(650));
    chk("frame_done_pulses", 32'(done_cnt), 32'(1));

    // Back-pressure: consumer stalls 20 cycles on the first result
    cur_dly = 2;
    sad_plan = '{77};
    ia.res_ready = 1'b0;
    pulse_start_a();
    n = 0;
    while (!ia.res_valid && n < 100) begin
      cyc(1);
      n++;
    end
    chk("stall_reach_output", 32'(ia.res_valid), 32'(1));
    n_req = 0;
    lost = 0;
    repeat (20) begin
      cyc(1);
      if (ia.me_req) n_req++;
      if (!ia.res_valid) lost++;
    end
    chk("stall_me_req", 32'(n_req), 32'(0));
    chk("stall_valid_drop", 32'(lost), 32'(0));
    chk("stall_sad", 32'(ia.res_sad), 32'(77));
    chk("stall_pos", 32'({ia.res_mb_y, ia.res_mb_x}), 32'(0));
    ia.res_ready = 1'b1;
    wait_idle_a(400);
    cyc(2);

    // Abort while waiting for ack to fall on the second MB, then restart
    cur_dly = 1; low_dly = 6;
    sad_plan = '{10, 20};
    res_log.delete(); done_cnt = 0;
    pulse_start_a();
    n = 0;
    while (!(res_log.size() >= 1 && ia.me_ack && !ia.me_req && ia.busy) && n < 200) begin
      cyc(1);
      n++;
    end
    chk("abort_reach_wait", 32'(n < 200), 32'(1));
    ia.abort = 1'b1;
    cyc(1);
    ia.abort = 1'b0;
    chk("abort_busy", 32'(ia.busy), 32'(0));
    chk("abort_valid", 32'(ia.res_valid), 32'(0));
    chk("abort_me_req", 32'(ia.me_req), 32'(0));
    cyc(10);
    chk("abort_results", 32'(res_log.size()), 32'(1));
    chk("abort_no_done", 32'(done_cnt), 32'(0));
    low_dly = 0;
    sad_plan = '{5};
    pulse_start_a();
    chk("restart_x", 32'(ia.mb_x), 32'(0));
    chk("restart_y", 32'(ia.mb_y), 32'(0));
    chk("restart_fsad", 32'(ia.frame_sad), 32'(0));
    wait_idle_a(400);
    cyc(2);

`ifdef ME_SKIP_EN
    // Skip threshold boundary: 64 skips, 65 does not
    cur_dly = 1;
    sad_plan = '{64, 65};
    res_log.delete(); mv_log.delete();
    pulse_start_a();
    wait_idle_a(400);
    cyc(2);
    if (res_log.size() >= 2 && mv_log.size() >= 2) begin
      chk("skip64_flag", 32'(res_log[0].skip), 32'(1));
      chk("skip64_mvec", 32'(res_log[0].mvec), 32'(0));
      chk("skip65_flag", 32'(res_log[1].skip), 32'(0));
      chk("skip65_mvec", 32'(res_log[1].mvec), 32'(mv_log[1]));
    end else begin
      chk("skip_results", 32'(res_log.size()), 32'(4));
    end
`endif

    // Asynchronous reset while a request is outstanding
    cur_dly = 8;
    pulse_start_a();
    n = 0;
    while (!ia.me_req && n < 50) begin
      cyc(1);
      n++;
    end
    chk("rst_mid_req_seen", 32'(ia.me_req), 32'(1));
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid", ia.busy, ia.done, ia.me_req, ia.res_valid, ia.mb_x, ia.mb_y,
                   ia.frame_sad, ia.res_sad, ia.res_mvec, ia.res_mb_x, ia.res_mb_y);
    cyc(2);
    @(negedge clk);
    #2 rst_n = 1'b1;
    cyc(4);
    chk("post_rst_busy", 32'(ia.busy), 32'(0));
    chk("post_rst_valid", 32'(ia.res_valid), 32'(0));
    chk("post_rst_done_cnt_window", 32'(ia.done), 32'(0));

    // Randomized traffic: random start/abort/ready and controller latencies
    rand_mode = 1;
    cur_dly = 0;
    sad_plan.delete();
    repeat (3000) begin
      ia.start     = ($urandom_range(0, 3) == 0);
      ia.abort     = ($urandom_range(0, 149) == 0);
      ia.res_ready = ($urandom_range(0, 2) != 0);
      cyc(1);
    end
    ia.start = 1'b0; ia.abort = 1'b0; ia.res_ready = 1'b1;
    wait_idle_a(400);
    cyc(2);

    // Saturation on the 32x32 instance: 260 results of 16'hFFFF
    bsum = '0;
    ib.start = 1'b1;
    cyc(1);
    ib.start = 1'b0;
    for (int k = 0; k < 260; k++) begin
      n = 0;
      while (!ib.me_req && n < 50) begin
        cyc(1);
        n++;
      end
      if (n >= 50) begin
        chk("sat_req_timeout", 32'(ib.me_req), 32'(1));
        break;
      end
      ib.me_ack = 1'b1;
      ib.me_min_sad = 16'hFFFF;
      cyc(1);
      ib.me_ack = 1'b0;
      cyc(1);
      chk("sat_valid", 32'(ib.res_valid), 32'(1));
      cyc(1);
      bsum = sat_add(bsum, 16'hFFFF);
      chk("sat_frame_sad", 32'(ib.frame_sad), 32'(bsum));
    end
    chk("sat_final", 32'(ib.frame_sad), 32'h00FFFFFF);
    chk("sat_pos_x", 32'(ib.mb_x), 32'(260 % COLS_B));
    chk("sat_pos_y", 32'(ib.mb_y), 32'(260 / COLS_B));
    ib.abort = 1'b1;
    cyc(1);
    ib.abort = 1'b0;
    chk("sat_abort_busy", 32'(ib.busy), 32'(0));
    cyc(2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
